// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic light sequencer: phase codes,
// one-hot lamp encodings {R,Y,G} and default phase durations in Enable ticks.
package tl_pkg;

  typedef enum logic [2:0] {
    AR_NS = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    AR_EW = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5
  } phase_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [3:0] G_TIME_DEF = 4'd10;
  localparam logic [3:0] Y_TIME_DEF = 4'd3;
  localparam logic [3:0] R_TIME_DEF = 4'd1;

endpackage

// File: rtl/phase_timer.sv
// 4-bit phase residency counter: synchronous clear has priority, then it
// counts on cnt_i unless sat_i holds the current value.
module phase_timer (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       cnt_i,
  input  logic       sat_i,
  output logic [3:0] count_o
);

  logic [3:0] count_q;

  always_ff @(posedge clk_i) begin
    if (clr_i)
      count_q <= 4'd0;
    else if (cnt_i && !sat_i)
      count_q <= count_q + 4'd1;
  end

  assign count_o = count_q;

endmodule

// File: rtl/traffic_light_sequencer.sv
// Six-phase two-way intersection sequencer timed in Enable ticks; main road
// green holds until demand. Optional pedestrian walk under TL_PED_WALK_EN.
module traffic_light_sequencer
  import tl_pkg::*;
#(
  parameter logic [3:0] G_TIME = G_TIME_DEF,
  parameter logic [3:0] Y_TIME = Y_TIME_DEF,
  parameter logic [3:0] R_TIME = R_TIME_DEF
) (
  input  logic       Clk,
  input  logic       Clear_n,
  input  logic       Enable,
  input  logic       EW_Sense,
  output logic [2:0] NS_Light,
  output logic [2:0] EW_Light,
  output logic [2:0] Phase
`ifdef TL_PED_WALK_EN
  ,
  input  logic       Ped_Req,
  output logic       Walk
`endif
);

  phase_e     phase_q, phase_d, phaseNext;
  logic [3:0] tmrVal, dur;
  logic       tmrClr, tmrCnt, tmrSat, isLast, illegal, demand;

  phase_timer u_timer (
    .clk_i  (Clk),
    .clr_i  (tmrClr),
    .cnt_i  (tmrCnt),
    .sat_i  (tmrSat),
    .count_o(tmrVal)
  );

  always_ff @(posedge Clk) begin
    if (!Clear_n)
      phase_q <= AR_NS;
    else
      phase_q <= phase_d;
  end

  // Duration and successor of the current phase; codes 6/7 are flagged illegal.
  always_comb begin
    dur       = R_TIME;
    phaseNext = AR_NS;
    illegal   = 1'b0;
    case (phase_q)
      AR_NS:   begin dur = R_TIME; phaseNext = NS_G;  end
      NS_G:    begin dur = G_TIME; phaseNext = NS_Y;  end
      NS_Y:    begin dur = Y_TIME; phaseNext = AR_EW; end
      AR_EW:   begin dur = R_TIME; phaseNext = EW_G;  end
      EW_G:    begin dur = G_TIME; phaseNext = EW_Y;  end
      EW_Y:    begin dur = Y_TIME; phaseNext = AR_NS; end
      default: illegal = 1'b1;
    endcase
  end

  assign isLast = (tmrVal == dur - 4'd1);

  always_comb begin
    phase_d = phase_q;
    tmrClr  = 1'b0;
    tmrCnt  = 1'b0;
    tmrSat  = 1'b0;
    if (illegal) begin
      phase_d = AR_NS;
      tmrClr  = 1'b1;
    end else if (Enable) begin
      if (!isLast) begin
        tmrCnt = 1'b1;
      end else if (phase_q == NS_G && !demand) begin
        tmrCnt = 1'b1;
        tmrSat = 1'b1;
      end else begin
        phase_d = phaseNext;
        tmrClr  = 1'b1;
      end
    end
    if (!Clear_n)
      tmrClr = 1'b1;
  end

  always_comb begin
    NS_Light = LAMP_R;
    EW_Light = LAMP_R;
    case (phase_q)
      NS_G:    NS_Light = LAMP_G;
      NS_Y:    NS_Light = LAMP_Y;
      EW_G:    EW_Light = LAMP_G;
      EW_Y:    EW_Light = LAMP_Y;
      default: ;
    endcase
  end

  assign Phase = phase_q;

`ifdef TL_PED_WALK_EN
  logic pending_q, walk_q, enterEwG, leaveEwG;

  assign enterEwG = (phase_q == AR_EW) && (phase_d == EW_G);
  assign leaveEwG = (phase_q == EW_G) && (phase_d != EW_G);

  // A request coinciding with EW_G entry goes straight into Walk.
  always_ff @(posedge Clk) begin
    if (!Clear_n) begin
      pending_q <= 1'b0;
      walk_q    <= 1'b0;
    end else if (enterEwG) begin
      walk_q    <= pending_q | Ped_Req;
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_q | Ped_Req;
      if (leaveEwG)
        walk_q <= 1'b0;
    end
  end

  assign demand = EW_Sense | pending_q;
  assign Walk   = walk_q;
`else
  assign demand = EW_Sense;
`endif

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Bench for traffic_light_sequencer: residency-count phase model checked every
// cycle, plus literal pins from the directed scenarios and random stimulus.
module tb_traffic_light_sequencer;

  logic       Clk = 1'b0;
  logic       Clear_n = 1'b0;
  logic       Enable = 1'b0;
  logic       EW_Sense = 1'b0;
  logic       Ped_Req = 1'b0;
  logic [2:0] NS_Light, EW_Light, Phase;
  logic       Walk;

  int checks = 0;
  int failures = 0;

  int durTab[6]  = '{1, 10, 3, 1, 10, 3};
  int nsLamp[6]  = '{4, 1, 2, 4, 4, 4};
  int ewLamp[6]  = '{4, 4, 4, 4, 1, 2};

  int mPhase = 0;
  int mTicks = 0;
  int mPend  = 0;
  int mWalk  = 0;

  traffic_light_sequencer dut (
    .Clk     (Clk),
    .Clear_n (Clear_n),
    .Enable  (Enable),
    .EW_Sense(EW_Sense),
    .NS_Light(NS_Light),
    .EW_Light(EW_Light),
    .Phase   (Phase)
`ifdef TL_PED_WALK_EN
    ,
    .Ped_Req (Ped_Req),
    .Walk    (Walk)
`endif
  );

`ifndef TL_PED_WALK_EN
  assign Walk = 1'b0;
`endif

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model: phase index 0..5, ticks spent in it; leave after durTab ticks
  // unless in NS green with no demand.
  task automatic modelStep();
    int oldPhase, newPhase;
    if (!Clear_n) begin
      mPhase = 0; mTicks = 0; mPend = 0; mWalk = 0;
    end else begin
      oldPhase = mPhase;
      newPhase = mPhase;
      if (Enable) begin
        if (mTicks + 1 >= durTab[mPhase] &&
            !(mPhase == 1 && !(EW_Sense || mPend != 0))) begin
          newPhase = (mPhase + 1) % 6;
          mTicks = 0;
        end else begin
          mTicks++;
        end
      end
`ifdef TL_PED_WALK_EN
      if (oldPhase == 3 && newPhase == 4) begin
        mWalk = (mPend != 0 || Ped_Req) ? 1 : 0;
        mPend = 0;
      end else begin
        mPend = (mPend != 0 || Ped_Req) ? 1 : 0;
        if (oldPhase == 4 && newPhase != 4) mWalk = 0;
      end
`endif
      mPhase = newPhase;
    end
  endtask

  task automatic checkOutput();
    check("phase", int'(Phase), mPhase);
    check("nsLight", int'(NS_Light), nsLamp[mPhase]);
    check("ewLight", int'(EW_Light), ewLamp[mPhase]);
`ifdef TL_PED_WALK_EN
    check("walk", int'(Walk), mWalk);
`endif
  endtask

  task automatic applyStimulus(input logic clrN, input logic en,
                               input logic sense, input logic ped);
    Clear_n  = clrN;
    Enable   = en;
    EW_Sense = sense;
    Ped_Req  = ped;
    @(posedge Clk);
    modelStep();
    @(negedge Clk);
    checkOutput();
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    check("resetPhase", int'(Phase), 0);
    check("resetNs", int'(NS_Light), 4);
    check("resetEw", int'(EW_Light), 4);

    // Continuous ticks with demand: 28-tick cycle.
    for (int k = 1; k <= 28; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      if (k == 1)  check("cycNsG", int'(Phase), 1);
      if (k == 11) check("cycNsY", int'(Phase), 2);
      if (k == 15) begin
        check("cycEwG", int'(Phase), 4);
        check("cycEwGLamp", int'(EW_Light), 1);
      end
      if (k == 25) check("cycEwY", int'(Phase), 5);
      if (k == 28) check("cycWrap", int'(Phase), 0);
    end

    // NS green hold without demand, exit on first demanded tick.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 50; k++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check("holdNsG", int'(Phase), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    check("holdExit", int'(Phase), 2);

    // Reset in EW green at timer 5.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    check("midEwG", int'(Phase), 4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    check("abortPhase", int'(Phase), 0);
    check("abortNs", int'(NS_Light), 4);
    check("abortEw", int'(EW_Light), 4);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    check("restartNsG", int'(Phase), 1);

`ifdef TL_PED_WALK_EN
    // Pedestrian request during held NS green.
    for (int k = 0; k < 12; k++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    check("pedHold", int'(Phase), 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check("pedExit", int'(Phase), 2);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check("pedEwG", int'(Phase), 4);
    check("pedWalkOn", int'(Walk), 1);
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check("pedEwY", int'(Phase), 5);
    check("pedWalkOff", int'(Walk), 0);
`endif

    // Strobe every 4th clock.
    for (int i = 0; i < 112; i++)
      applyStimulus(1'b1, (i % 4) == 3, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) != 0,
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 39) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_sequencer.md
# traffic_light_sequencer

Phase sequencer for a two-way intersection (north–south main road, east–west side road). It steps a fixed six-phase cycle and times each phase with a 4-bit phase timer. The timer advances only on `Enable` strobes from the system tick divider. The block sits between the tick divider and the lamp drivers. Main-road green is held until the side-road sensor demands service.

## Interface
Parameters (each 4-bit, legal range 1..15; each value is a duration in `Enable` ticks):
- `G_TIME`, default 10: green phase duration.
- `Y_TIME`, default 3: yellow phase duration.
- `R_TIME`, default 1: all-red clearance phase duration.

Ports (one clock; reset is synchronous and active-low):
- `Clk` input 1: rising-edge clock.
- `Clear_n` input 1: synchronous active-low reset; wins over every other input.
- `Enable` input 1: one-cycle tick strobe; all timing is counted in these ticks.
- `EW_Sense` input 1: side-road vehicle present; level input, sampled on ticks.
- `NS_Light` output 3: one-hot {R,Y,G}, bit 2 = R.
- `EW_Light` output 3: one-hot {R,Y,G}, bit 2 = R.
- `Phase` output 3: current phase code.
- `Ped_Req` input 1: only when `TL_PED_WALK_EN` is defined.
- `Walk` output 1: only when `TL_PED_WALK_EN` is defined.

## Operation
- Phase codes and lamps:
  - 0 AR_NS: all red, `R_TIME`.
  - 1 NS_G: NS green, EW red, minimum `G_TIME`.
  - 2 NS_Y: NS yellow, `Y_TIME`.
  - 3 AR_EW: all red, `R_TIME`.
  - 4 EW_G: EW green, `G_TIME`.
  - 5 EW_Y: EW yellow, `Y_TIME`, then back to 0.
  - Codes 6 and 7 are illegal; they recover to AR_NS on the next clock.
- Timer behaviour:
  - Cleared on every phase entry.
  - Increments once per `Enable`.
- Phase exit rule: a phase of duration T exits on the `Enable` at which timer == T-1, i.e. exactly T ticks of residency.
- NS_G exception:
  - At timer == G_TIME-1 the phase exits only if a demand is present (`EW_Sense`=1, or pending pedestrian request).
  - Otherwise the timer saturates at G_TIME-1 and NS_G holds indefinitely.
  - The first tick with demand then exits.
- EW_G always lasts exactly `G_TIME`; `EW_Sense` is ignored outside NS_G.
- Lamp outputs are Moore-decoded from the registered state.
  - Exactly one lamp per direction is lit.
  - Green or yellow is never shown on both directions at once.
- `Enable`=0 freezes the state and the timer.

## Timing
- Reset (`Clear_n`=0 at a rising edge):
  - Phase=0, timer=0, `NS_Light`=3'b100, `EW_Light`=3'b100, `Walk`=0, pending=0.
  - Reset mid-phase aborts immediately; the lights are all red on the following cycle.
- Phase changes take effect on the same edge that samples the qualifying `Enable`. Outputs update in that cycle; there is no extra pipeline delay.
- Full cycle with continuous demand: 2·R_TIME + 2·G_TIME + 2·Y_TIME ticks (28 with the defaults).
- `Enable` held high continuously is legal: one tick per clock.
- `EW_Sense` is sampled only on `Enable` cycles; pulses between ticks are missed.

## Configuration
- Macro `TL_PED_WALK_EN` defined:
  - `Ped_Req` pulses (any cycle, no `Enable` needed) set a pending flag.
  - Pending counts as demand for the NS_G exit.
  - On entry to EW_G, pending is copied into `Walk` and then cleared.
  - `Walk` stays high for the whole of EW_G and drops on entry to EW_Y.
  - A request arriving during EW_G sets pending for the next cycle.
  - A request on the same edge as the EW_G entry is captured into `Walk`.
- Macro undefined: the `Ped_Req`/`Walk` ports and the pending flag do not exist; demand is `EW_Sense` only.

## Structure
- Shared package `tl_pkg`:
  - Phase enum (6 codes above).
  - Lamp constants `LAMP_R`=3'b100, `LAMP_Y`=3'b010, `LAMP_G`=3'b001.
  - Default duration constants.
- Sub-module `phase_timer`: 4-bit up-counter with synchronous clear and count-enable, plus a saturate input for NS_G hold. It is instantiated once; the FSM drives its clear and count.

## Test plan
- Reset, `Enable`=1 each clock, `EW_Sense`=1 → Phase sequence 0(1 clk), 1(10), 2(3), 3(1), 4(10), 5(3), then 0 again. Lamps match each phase; period is 28 clocks.
- `EW_Sense`=0 → NS_G held for 50 ticks. Raise `EW_Sense` → NS_Y on the very next tick.
- `Enable` strobe every 4th clock → every phase residency is 4× the tick count. State and timer are frozen between strobes.
- `Clear_n` low during EW_G at timer=5 → next cycle Phase=0 and both directions red. Restart timing matches the first scenario.
- (`TL_PED_WALK_EN` defined) `EW_Sense`=0, `Ped_Req` pulse during NS_G after G_TIME → NS_Y next tick. `Walk`=1 for all 10 ticks of EW_G, 0 from EW_Y on.
- (`TL_PED_WALK_EN` defined) `Ped_Req` pulse during EW_G → `Walk` stays 0 for the current EW_G, and next EW_G has `Walk`=1.
